// File: rtl/gate_sequence_accumulator_pkg.sv
// Shared types and constants for the gate-sequence accumulator: Q2.35 complex words,
// 2x2 complex matrices, the identity matrix and the controller state encoding.
package gate_sequence_accumulator_pkg;

    // Signed fixed-point word, Q2.35: 1.0 is 2**35.
    localparam int unsigned WIDTH = 37;
    localparam int unsigned FRAC  = 35;

    // Last index of a matrix element selects the real or imaginary part.
    localparam int unsigned IDX_RE = 0;
    localparam int unsigned IDX_IM = 1;

    typedef logic signed [WIDTH-1:0] cfixed_t;

    // Indexed [row][col][re/im].
    typedef cfixed_t [0:1][0:1][0:1] cmatrix_t;

    localparam cfixed_t ONE = 37'sd34359738368;

    typedef enum logic [1:0] {
        S_ACCEPT,
        S_WAIT,
        S_OUT,
        S_ERR
    } state_t;

    // Identity: real part ONE on the diagonal, every other word zero.
    function automatic cmatrix_t identity_matrix();
        cmatrix_t m;
        m = '0;
        m[0][0][IDX_RE] = ONE;
        m[1][1][IDX_RE] = ONE;
        return m;
    endfunction

    localparam cmatrix_t CMATRIX_IDENTITY = identity_matrix();

endpackage

// File: rtl/gate_sequence_accumulator_if.sv
// Bundle of the gate stream, multiplier handshake and unitary output of the accumulator.
// The slave modport is the accumulator's view; master is the surrounding logic's view.
interface gate_sequence_accumulator_if #(
    parameter int unsigned CNT_W = 8
);
    import gate_sequence_accumulator_pkg::*;

    // Gate stream from the decode front end
    cmatrix_t         gate_in;
    logic             gate_valid;
    logic             gate_last;
    logic             gate_ready;

    // Sibling complex_matrix_multiplier
    cmatrix_t         mul_a;
    cmatrix_t         mul_b;
    logic             mul_ready;
    cmatrix_t         mul_r;
    logic             mul_available;

    // Downstream state-vector stage
    cmatrix_t         unitary_out;
    logic             unitary_valid;
    logic             unitary_ack;

    // Status
    logic [CNT_W-1:0] gate_count;
    logic             error;

    modport slave (
        input  gate_in,
        input  gate_valid,
        input  gate_last,
        input  mul_r,
        input  mul_available,
        input  unitary_ack,
        output gate_ready,
        output mul_a,
        output mul_b,
        output mul_ready,
        output unitary_out,
        output unitary_valid,
        output gate_count,
        output error
    );

    modport master (
        output gate_in,
        output gate_valid,
        output gate_last,
        output mul_r,
        output mul_available,
        output unitary_ack,
        input  gate_ready,
        input  mul_a,
        input  mul_b,
        input  mul_ready,
        input  unitary_out,
        input  unitary_valid,
        input  gate_count,
        input  error
    );

endinterface

// File: rtl/gate_sequence_accumulator.sv
// Folds a stream of 2x2 complex gates into one composite unitary U = Gn*...*G1.
// Each accepted gate is presented to the external multiplier as A = gate, B = accumulator;
// the product replaces the accumulator. The sequence ends with the gate tagged last, whose
// product is published on unitary_out until the downstream stage acknowledges it.
// No arithmetic happens here: the multiplier owns rounding and saturation.
module gate_sequence_accumulator
    import gate_sequence_accumulator_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned MUL_TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    gate_sequence_accumulator_if.slave  bus
);

    localparam int unsigned TMO_W = $clog2(MUL_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MUL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q;
    state_t            state_d;
    cmatrix_t          gate_q;
    logic              last_q;
    cmatrix_t          acc_q;
    cmatrix_t          unitary_q;
    logic              valid_q;
    logic [CNT_W-1:0]  count_q;
    logic [TMO_W-1:0]  tmo_q;

    logic              accept;
    logic              mul_done;
    logic              timeout;
    logic              out_ack;

    // Events that move the FSM and the datapath registers.
    always_comb begin
        accept   = (state_q == S_ACCEPT) && bus.gate_valid;
        // mul_available outside S_WAIT is deliberately ignored.
        mul_done = (state_q == S_WAIT) && bus.mul_available;
        // Timeout fires on the cycle the counter would reach MUL_TIMEOUT, so S_ERR is
        // entered exactly MUL_TIMEOUT cycles after S_WAIT was entered.
        timeout  = (state_q == S_WAIT) && !bus.mul_available && (tmo_q == TMO_LAST);
        // An ack only counts while a unitary is actually being offered.
        out_ack  = (state_q == S_OUT) && bus.unitary_ack && valid_q;
    end

    // Next-state logic and output decode.
    always_comb begin
        state_d           = state_q;
        bus.gate_ready    = 1'b0;
        bus.mul_ready     = 1'b0;
        bus.error         = 1'b0;
        bus.mul_a         = gate_q;
        bus.mul_b         = acc_q;
        bus.unitary_out   = unitary_q;
        bus.unitary_valid = valid_q;
        bus.gate_count    = count_q;

        unique case (state_q)
            S_ACCEPT: begin
                // Held low while reset is asserted; ready appears once reset releases.
                bus.gate_ready = !reset;
                if (accept) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                bus.mul_ready = 1'b1;
                if (mul_done) begin
                    state_d = last_q ? S_OUT : S_ACCEPT;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_OUT: begin
                if (out_ack) begin
                    state_d = S_ACCEPT;
                end
            end
            S_ERR: begin
                // Terminal until reset.
                bus.error = 1'b1;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the incoming gate and its last flag; held through S_WAIT as operand A.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate_q <= '0;
            last_q <= 1'b0;
        end else if (accept) begin
            gate_q <= bus.gate_in;
            last_q <= bus.gate_last;
        end
    end

    // Accumulator: takes each product, returns to identity once a unitary is consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= CMATRIX_IDENTITY;
        end else if (mul_done) begin
            acc_q <= bus.mul_r;
        end else if (out_ack) begin
            acc_q <= CMATRIX_IDENTITY;
        end
    end

    // Output register: loaded with the final product, valid until acknowledged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            unitary_q <= '0;
            valid_q   <= 1'b0;
        end else if (mul_done && last_q) begin
            unitary_q <= bus.mul_r;
            valid_q   <= 1'b1;
        end else if (out_ack) begin
            valid_q   <= 1'b0;
        end
    end

    // Saturating count of gates folded into the current sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (mul_done) begin
            if (count_q != CNT_MAX) begin
                count_q <= count_q + 1'b1;
            end
        end else if (out_ack) begin
            count_q <= '0;
        end
    end

    // Multiplier watchdog: zero outside S_WAIT, so it starts at 0 on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else if (state_q == S_WAIT) begin
            tmo_q <= tmo_q + 1'b1;
        end else begin
            tmo_q <= '0;
        end
    end

endmodule
